prog_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 15 +
 rtl/uart_rx.sv | 90 +++++++++
 rtl/prog_loader.sv | 106 ++++++++++
 tb/tb_prog_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared constants for the serial program loader: sync marker and loader FSM encoding.
// Pure declarations, no logic, no latency, no flow control.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    WAIT_SYNC = 3'd0,
    GET_LEN   = 3'd1,
    GET_HI    = 3'd2,
    GET_LO    = 3'd3,
    GET_SUM   = 3'd4
  } loadState_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer and mid-bit sampling.
// Byte-valid pulses 1 cycle after the stop-bit mid-sample; no backpressure, the consumer must take every byte.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frameErr
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  rxState_t       rxState;
  logic           rxMeta;
  logic           rxSync;
  logic           rxPrev;
  logic [CW-1:0]  baudCnt;
  logic [2:0]     bitIdx;
  logic [7:0]     shiftReg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rxMeta     <= 1'b1;
      rxSync     <= 1'b1;
      rxPrev     <= 1'b1;
      rxState    <= RX_IDLE;
      baudCnt    <= '0;
      bitIdx     <= '0;
      shiftReg   <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_frameErr <= 1'b0;
    end else begin
      rxMeta     <= i_rx;
      rxSync     <= rxMeta;
      rxPrev     <= rxSync;
      o_valid    <= 1'b0;
      o_frameErr <= 1'b0;
      case (rxState)
        RX_IDLE: begin
          baudCnt <= '0;
          // Only a genuine 1->0 transition starts a byte, so a line stuck low after a bad stop bit is ignored.
          if (rxPrev && !rxSync) rxState <= RX_START;
        end
        RX_START: begin
          if (baudCnt == HALF_M1) begin
            baudCnt <= '0;
            bitIdx  <= '0;
            rxState <= rxSync ? RX_IDLE : RX_DATA;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (baudCnt == FULL_M1) begin
            baudCnt  <= '0;
            shiftReg <= {rxSync, shiftReg[7:1]};
            if (bitIdx == 3'd7) rxState <= RX_STOP;
            else                bitIdx  <= bitIdx + 1'b1;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (baudCnt == FULL_M1) begin
            baudCnt <= '0;
            rxState <= RX_IDLE;
            if (rxSync) begin
              o_data  <= shiftReg;
              o_valid <= 1'b1;
            end else begin
              o_frameErr <= 1'b1;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        default: rxState <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a framed, checksummed program image from UART into instruction memory and gates CPU reset.
// Write strobe 1 cycle after each word's second byte; flags 1 cycle after byte-valid; no backpressure on the write port.
module prog_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rx,
  output logic                  o_instrWe,
  output logic [ADDR_WIDTH-1:0] o_instrAddr,
  output logic [15:0]           o_instrData,
  output logic                  o_cpuReset,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxFrameErr;
  loadState_t  state;
  logic [8:0]  wordCnt;
  logic [7:0]  sum;
  logic [7:0]  opcode;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rx       (i_rx),
    .o_data     (rxData),
    .o_valid    (rxValid),
    .o_frameErr (rxFrameErr)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= WAIT_SYNC;
      wordCnt     <= '0;
      sum         <= '0;
      opcode      <= '0;
      o_instrWe   <= 1'b0;
      o_instrAddr <= '0;
      o_instrData <= '0;
      o_cpuReset  <= 1'b1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      o_instrWe <= 1'b0;
      // Address moves on only after the strobe cycle so addr/data stay stable while We is high.
      if (o_instrWe) o_instrAddr <= o_instrAddr + 1'b1;

      if (rxFrameErr && state != WAIT_SYNC) begin
        o_error    <= 1'b1;
        o_busy     <= 1'b0;
        o_cpuReset <= 1'b1;
        state      <= WAIT_SYNC;
      end else if (rxValid) begin
        case (state)
          WAIT_SYNC: begin
            if (rxData == SYNC_BYTE) begin
              o_cpuReset  <= 1'b1;
              o_done      <= 1'b0;
              o_error     <= 1'b0;
              o_busy      <= 1'b1;
              o_instrAddr <= '0;
              sum         <= '0;
              state       <= GET_LEN;
            end
          end
          GET_LEN: begin
            wordCnt <= (rxData == 8'd0) ? 9'd256 : {1'b0, rxData};
            state   <= GET_HI;
          end
          GET_HI: begin
            opcode <= rxData;
            sum    <= sum + rxData;
            state  <= GET_LO;
          end
          GET_LO: begin
            sum         <= sum + rxData;
            o_instrWe   <= 1'b1;
            o_instrData <= {opcode, rxData};
            wordCnt     <= wordCnt - 1'b1;
            state       <= (wordCnt == 9'd1) ? GET_SUM : GET_HI;
          end
          GET_SUM: begin
            if (rxData == sum) begin
              o_done     <= 1'b1;
              o_cpuReset <= 1'b0;
            end else begin
              o_error <= 1'b1;
            end
            o_busy <= 1'b0;
            state  <= WAIT_SYNC;
          end
          default: state <= WAIT_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of frames plus hand-written corner sequences.
module tb_prog_loader;

  localparam int CPB = 4;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b1;
  logic          instrWe;
  logic [AW-1:0] instrAddr;
  logic [15:0]   instrData;
  logic          cpuReset, busy, done, error;

  always #5 clk = ~clk;

  prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_rx        (rx),
    .o_instrWe   (instrWe),
    .o_instrAddr (instrAddr),
    .o_instrData (instrData),
    .o_cpuReset  (cpuReset),
    .o_busy      (busy),
    .o_done      (done),
    .o_error     (error)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  typedef struct {
    logic [7:0] len;
    logic [7:0] base;
    logic [7:0] step;
    logic       sumBad;
    logic       expDone;
    logic       expErr;
    logic       expCpuRst;
  } vec_t;

  wr_t        expQ[$];
  logic [7:0] txQ[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         writesSeen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write-port scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (instrWe === 1'b1) begin
      writesSeen++;
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", instrAddr, instrData);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        check("write_addr", 32'(instrAddr), 32'(e.addr));
        check("write_data", 32'(instrData), 32'(e.data));
      end
    end
  end

  task automatic bitWait();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    rx = 1'b0;
    bitWait();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bitWait();
    end
    rx = stopBit;
    bitWait();
    rx = 1'b1;
    bitWait();
    bitWait();
  endtask

  task automatic sendQ();
    while (txQ.size() > 0) sendByte(txQ.pop_front(), 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Builds LEN, data and SUM bytes (sync sent separately) and queues the expected writes.
  task automatic buildFrame(input logic [7:0] len, input logic [7:0] base, input logic [7:0] step,
                            input logic sumBad);
    int         nBytes;
    logic [7:0] b, hi, s;
    nBytes = (len == 8'd0) ? 512 : 2 * int'(len);
    s = 8'd0;
    hi = 8'd0;
    txQ.push_back(len);
    for (int k = 0; k < nBytes; k++) begin
      b = base + 8'(step * k);
      s = s + b;
      txQ.push_back(b);
      if (k % 2 == 0) hi = b;
      else expQ.push_back('{addr: AW'(k / 2), data: {hi, b}});
    end
    txQ.push_back(sumBad ? s + 8'd1 : s);
  endtask

  task automatic checkFlags(input string tag, input logic expBusy, input logic expDone,
                            input logic expErr, input logic expCpuRst);
    check({tag, "_busy"}, 32'(busy), 32'(expBusy));
    check({tag, "_done"}, 32'(done), 32'(expDone));
    check({tag, "_error"}, 32'(error), 32'(expErr));
    check({tag, "_cpuReset"}, 32'(cpuReset), 32'(expCpuRst));
  endtask

  task automatic checkResetVals(input string tag);
    checkFlags(tag, 1'b0, 1'b0, 1'b0, 1'b1);
    check({tag, "_we"}, 32'(instrWe), 32'd0);
    check({tag, "_addr"}, 32'(instrAddr), 32'd0);
    check({tag, "_data"}, 32'(instrData), 32'd0);
  endtask

  task automatic runFrame(input string tag, input vec_t v);
    sendByte(8'hA5, 1'b1);
    idle(12);
    checkFlags({tag, "_sync"}, 1'b1, 1'b0, 1'b0, 1'b1);
    buildFrame(v.len, v.base, v.step, v.sumBad);
    sendQ();
    idle(12);
    checkFlags({tag, "_end"}, 1'b0, v.expDone, v.expErr, v.expCpuRst);
    check({tag, "_final_addr"}, 32'(instrAddr), 32'(v.len));
    check({tag, "_pending_writes"}, 32'(expQ.size()), 32'd0);
  endtask

  vec_t vecs[4];
  int   wBefore;

  initial begin
    vecs[0] = '{len: 8'h02, base: 8'h11, step: 8'h11, sumBad: 1'b0, expDone: 1'b1, expErr: 1'b0, expCpuRst: 1'b0};
    vecs[1] = '{len: 8'h02, base: 8'h11, step: 8'h11, sumBad: 1'b1, expDone: 1'b0, expErr: 1'b1, expCpuRst: 1'b1};
    vecs[2] = '{len: 8'h00, base: 8'h01, step: 8'h00, sumBad: 1'b0, expDone: 1'b1, expErr: 1'b0, expCpuRst: 1'b0};
    vecs[3] = '{len: 8'h03, base: 8'hA5, step: 8'h00, sumBad: 1'b0, expDone: 1'b1, expErr: 1'b0, expCpuRst: 1'b0};

    // Reset and long idle line
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    checkResetVals("post_reset");
    idle(1000);
    checkResetVals("idle");
    check("idle_no_writes", 32'(writesSeen), 32'd0);

    for (int i = 0; i < 4; i++) runFrame($sformatf("vec%0d", i), vecs[i]);

    // Junk bytes before sync are ignored
    sendByte(8'h00, 1'b1);
    sendByte(8'h5A, 1'b1);
    idle(12);
    check("junk_busy", 32'(busy), 32'd0);
    runFrame("after_junk", vecs[0]);

    // Bad stop bit on third data byte
    sendByte(8'hA5, 1'b1);
    txQ.push_back(8'h02);
    txQ.push_back(8'h11);
    txQ.push_back(8'h22);
    expQ.push_back('{addr: AW'(0), data: 16'h1122});
    sendQ();
    sendByte(8'h33, 1'b0);
    idle(12);
    checkFlags("frame_err", 1'b0, 1'b0, 1'b1, 1'b1);
    check("frame_err_pending", 32'(expQ.size()), 32'd0);
    runFrame("after_frame_err", vecs[0]);

    // Reset mid-frame after three data bytes
    sendByte(8'hA5, 1'b1);
    txQ.push_back(8'h02);
    txQ.push_back(8'h11);
    txQ.push_back(8'h22);
    txQ.push_back(8'h33);
    expQ.push_back('{addr: AW'(0), data: 16'h1122});
    sendQ();
    idle(4);
    check("midframe_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkResetVals("midframe_reset");
    wBefore = writesSeen;
    sendByte(8'h44, 1'b1);
    sendByte(8'hAA, 1'b1);
    idle(12);
    checkResetVals("after_abort");
    check("after_abort_no_writes", 32'(writesSeen - wBefore), 32'd0);
    check("final_pending_writes", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
